// File: rtl/fb_pkg.sv
// Shared frame-buffer and 640x480@60 VGA definitions, reused by the memory,
// the game-side writer and the scanout reader.
package fb_pkg;

    localparam int FB_W     = 120;
    localparam int FB_H     = 60;
    localparam int FB_DEPTH = 7200;
    localparam int FB_AW    = 16;

    typedef logic [2:0] pixel_t;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int CNT_W = 10;

    // Per-pixel control bits carried from the counter stage to the pin stage.
    typedef struct packed {
        logic active;
        logic in_pic;
        logic grid;
        logic hsync;
        logic vsync;
    } stage_t;

    localparam stage_t STAGE_RST = '{active: 1'b0, in_pic: 1'b0, grid: 1'b0,
                                     hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/vga_timing.sv
// 25 MHz pixel enable, h/v raster counters and raw sync/active decode;
// vblank and frame_start are registered from the counters.
module vga_timing
    import fb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             pix_en_o,
    output logic [CNT_W-1:0] h_o,
    output logic [CNT_W-1:0] v_o,
    output logic             h_last_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             active_o,
    output logic             vblank_o,
    output logic             frame_start_o
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_B   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_E   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_B   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_E   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             pix_en_q;
    logic [CNT_W-1:0] h_q, v_q;
    logic             vblank_q, frame_start_q;
    logic             h_wrap, v_wrap;

    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_en_q      <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_en_q      <= !pix_en_q;
            vblank_q      <= (v_q >= V_ACT);
            frame_start_q <= pix_en_q && h_wrap && v_wrap;
            if (pix_en_q) begin
                h_q <= h_wrap ? '0 : h_q + 1'b1;
                if (h_wrap)
                    v_q <= v_wrap ? '0 : v_q + 1'b1;
            end
        end
    end

    assign pix_en_o      = pix_en_q;
    assign h_o           = h_q;
    assign v_o           = v_q;
    assign h_last_o      = h_wrap;
    assign hsync_o       = !((h_q >= HS_B) && (h_q < HS_E));
    assign vsync_o       = !((v_q >= VS_B) && (v_q < VS_E));
    assign active_o      = (h_q < H_ACT) && (v_q < V_ACT);
    assign vblank_o      = vblank_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/fb_scanout.sv
// Frame buffer scanout: multiplier-free cell address generation and a
// two-tick output pipeline. Optional cell grid overlay: FB_SCANOUT_GRID_EN.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int     SCALE  = 4,
    parameter int     X0     = 80,
    parameter int     Y0     = 120,
    parameter pixel_t BORDER = 3'b001
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [FB_AW-1:0] raddr_o,
    input  pixel_t           rdata_i,
    output logic             hsync_o,
    output logic             vsync_o,
    output pixel_t           rgb_o,
    output logic             vblank_o,
    output logic             frame_start_o
);

    localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int COL_W = $clog2(FB_W);

    localparam logic [CNT_W-1:0] X_B = CNT_W'(X0);
    localparam logic [CNT_W-1:0] X_E = CNT_W'(X0 + FB_W * SCALE);
    localparam logic [CNT_W-1:0] Y_B = CNT_W'(Y0);
    localparam logic [CNT_W-1:0] Y_L = CNT_W'(Y0 + FB_H * SCALE - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FB_W - 1);

    logic             pix_en, h_last, hs_raw, vs_raw, active;
    logic [CNT_W-1:0] h, v;

    vga_timing u_timing (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .pix_en_o     (pix_en),
        .h_o          (h),
        .v_o          (v),
        .h_last_o     (h_last),
        .hsync_o      (hs_raw),
        .vsync_o      (vs_raw),
        .active_o     (active),
        .vblank_o     (vblank_o),
        .frame_start_o(frame_start_o)
    );

    logic             in_x, in_y, in_pic, grid;
    logic [SUB_W-1:0] subx_q, suby_q;
    logic [COL_W-1:0] col_q;
    logic [FB_AW-1:0] row_base_q, raddr_q;
    stage_t           st1_q, st1_d;
    pixel_t           rgb_q, rgb_d;
    logic             hsync_q, vsync_q;

    assign in_x   = (h >= X_B) && (h < X_E);
    assign in_y   = (v >= Y_B) && (v <= Y_L);
    assign in_pic = in_x && in_y;

`ifdef FB_SCANOUT_GRID_EN
    assign grid = in_pic && ((subx_q == '0) || (suby_q == '0));
`else
    assign grid = 1'b0;
`endif

    always_comb begin
        st1_d = '{active: active, in_pic: in_pic, grid: grid,
                  hsync: hs_raw, vsync: vs_raw};
        rgb_d = '0;
        if (st1_q.active)
            rgb_d = !st1_q.in_pic ? BORDER : (st1_q.grid ? 3'b111 : rdata_i);
    end

    // subx/col follow the current h, suby/row_base follow the current line;
    // both fall back to 0 outside the picture so each frame starts clean.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            subx_q     <= '0;
            suby_q     <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            raddr_q    <= '0;
            st1_q      <= STAGE_RST;
            rgb_q      <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else if (pix_en) begin
            if (in_x) begin
                subx_q <= (subx_q == SUB_LAST) ? '0 : subx_q + 1'b1;
                if (subx_q == SUB_LAST)
                    col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
            end else begin
                subx_q <= '0;
                col_q  <= '0;
            end
            if (h_last) begin
                if (in_y) begin
                    suby_q <= (suby_q == SUB_LAST) ? '0 : suby_q + 1'b1;
                    // The final row group never advances, so the base stays inside the buffer.
                    if (suby_q == SUB_LAST && v != Y_L)
                        row_base_q <= row_base_q + FB_AW'(FB_W);
                end else begin
                    suby_q     <= '0;
                    row_base_q <= '0;
                end
            end
            if (in_pic)
                raddr_q <= row_base_q + FB_AW'(col_q);
            st1_q   <= st1_d;
            rgb_q   <= rgb_d;
            hsync_q <= st1_q.hsync;
            vsync_q <= st1_q.vsync;
        end
    end

    assign raddr_o = raddr_q;
    assign rgb_o   = rgb_q;
    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: screen-coordinate vector table, timing measurements and a
// per-clock raster reference model over a randomized frame buffer.
module tb_fb_scanout;
    import fb_pkg::*;

`ifdef FB_SCANOUT_GRID_EN
    localparam bit GRID = 1'b1;
`else
    localparam bit GRID = 1'b0;
`endif
    localparam int FRAME_PIX = 800 * 525;
    localparam int FRAME_CLK = 2 * FRAME_PIX;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] raddr;
    pixel_t      rdata, rgb;
    logic        hsync, vsync, vblank, frame_start;
    pixel_t      ram [FB_DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    fb_scanout dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .raddr_o      (raddr),
        .rdata_i      (rdata),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .rgb_o        (rgb),
        .vblank_o     (vblank),
        .frame_start_o(frame_start)
    );

    always #10 clk = ~clk;

    always_comb begin
        rdata = '0;
        if (int'(raddr) < FB_DEPTH) rdata = ram[int'(raddr)];
    end

    typedef struct { logic hs, vs, vb, fs; pixel_t rgb; } exp_t;
    typedef struct { string name; int h, v; pixel_t rgb; logic hs, vs, vb; } vec_t;
    vec_t tbl[$];

    // measurements gathered during a scan
    int first_hs, hs_fall, hs_per, hs_low, vs_fall, vs_first, vs_low, fs_cnt, fs_n;
    logic [15:0] max_ra;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Colour seen at screen pixel (h,v), straight from the picture geometry.
    function automatic pixel_t pix_of(int h, int v);
        if (h >= 640 || v >= 480) return 3'b000;
        if (h < 80 || h >= 560 || v < 120 || v >= 360) return 3'b001;
        if (GRID && ((h - 80) % 4 == 0 || (v - 120) % 4 == 0)) return 3'b111;
        return ram[((v - 120) / 4) * 120 + (h - 80) / 4];
    endfunction

    // Expected pins after n clock edges since reset release.
    function automatic exp_t model(int n);
        exp_t e;
        int t, p, h, v;
        e.hs = 1'b1; e.vs = 1'b1; e.vb = 1'b0; e.fs = 1'b0; e.rgb = '0;
        t = n / 2;
        if (t >= 2) begin
            p = (t - 2) % FRAME_PIX;
            h = p % 800;
            v = p / 800;
            e.hs  = !(h >= 656 && h < 752);
            e.vs  = !(v >= 490 && v < 492);
            e.rgb = pix_of(h, v);
        end
        if (n >= 1) e.vb = ((((n - 1) / 2) % FRAME_PIX) / 800) >= 480;
        e.fs = (n > 0) && (n % 2 == 0) && ((n / 2) % FRAME_PIX == 0);
        return e;
    endfunction

    task automatic scan(input int nmax);
        exp_t e;
        logic ph, pv;
        int   errs;
        first_hs = -1; hs_fall = -1; hs_per = -1; hs_low = -1;
        vs_fall = -1; vs_first = -1; vs_low = -1; fs_cnt = 0; fs_n = -1; max_ra = '0;
        ph = hsync; pv = vsync; errs = 0;
        for (int n = 1; n <= nmax; n++) begin
            @(posedge clk);
            @(negedge clk);
            e = model(n);
            if ({rgb, hsync, vsync, vblank, frame_start} !== {e.rgb, e.hs, e.vs, e.vb, e.fs}
                || raddr > 16'(FB_DEPTH - 1)) begin
                if (errs == 0)
                    $display("FAIL scan n=%0d: got rgb=%0d hs=%0b vs=%0b vb=%0b fs=%0b raddr=%0d expected rgb=%0d hs=%0b vs=%0b vb=%0b fs=%0b",
                             n, rgb, hsync, vsync, vblank, frame_start, raddr, e.rgb, e.hs, e.vs, e.vb, e.fs);
                errs++;
            end
            if (n % 1600 == 0 || n == nmax) begin
                n_cmp++;
                if (errs != 0) n_bad++;
                errs = 0;
            end
            foreach (tbl[i])
                if (n == 2 * (tbl[i].v * 800 + tbl[i].h + 2) + 1)
                    check(tbl[i].name, {rgb, hsync, vsync, vblank},
                          {tbl[i].rgb, tbl[i].hs, tbl[i].vs, tbl[i].vb});
            if (ph && !hsync) begin
                if (first_hs < 0) first_hs = n;
                else if (hs_per < 0) hs_per = n - hs_fall;
                hs_fall = n;
            end
            if (!ph && hsync && hs_fall >= 0 && hs_low < 0) hs_low = n - hs_fall;
            if (pv && !vsync) begin
                vs_fall = n;
                if (vs_first < 0) vs_first = n;
            end
            if (!pv && vsync && vs_fall >= 0 && vs_low < 0) vs_low = n - vs_fall;
            if (frame_start) begin fs_cnt++; fs_n = n; end
            if (raddr > max_ra) max_ra = raddr;
            ph = hsync; pv = vsync;
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_hsync"}, hsync, 1);
        check({tag, "_vsync"}, vsync, 1);
        check({tag, "_rgb"}, rgb, 0);
        check({tag, "_raddr"}, raddr, 0);
        check({tag, "_vblank"}, vblank, 0);
        check({tag, "_fstart"}, frame_start, 0);
    endtask

    initial begin
        // Cells used by the vector table follow ram[a]=a[2:0]; the rest is random.
        for (int a = 0; a < FB_DEPTH; a++)
            ram[a] = (a < 240 || a == FB_DEPTH - 1) ? 3'(a) : 3'($urandom);

        tbl.push_back('{"pic_origin", 80, 120, GRID ? 3'b111 : 3'b000, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{"cell1", 84, 120, GRID ? 3'b111 : 3'b001, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{"row1", 80, 124, GRID ? 3'b111 : 3'b000, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{"row0_last", 559, 120, 3'b111, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{"last_pix", 559, 359, 3'b111, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{"border_00", 0, 0, 3'b001, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{"border_l", 79, 120, 3'b001, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{"border_r", 560, 200, 3'b001, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{"hblank700", 700, 0, 3'b000, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{"vblank500", 0, 500, 3'b000, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{"grid_on", 84, 121, GRID ? 3'b111 : 3'b001, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{"grid_off", 85, 121, 3'b001, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{"hs_before", 655, 5, 3'b000, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{"hs_start", 656, 5, 3'b000, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{"hs_end", 752, 5, 3'b000, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{"vs_low", 100, 490, 3'b000, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{"vs_end", 100, 492, 3'b000, 1'b1, 1'b1, 1'b1});

        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_reset_pins("reset");
        rst_n = 1'b1;

        // Run into the frame up to h=300,v=200 then pull reset asynchronously.
        scan(2 * (200 * 800 + 300));
        check("pre_rst_first_hs", first_hs, 2 * (656 + 2));
        #($urandom_range(1, 8));
        rst_n = 1'b0;
        #1;
        check_reset_pins("async_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Full frame from the restart point.
        scan(FRAME_CLK + 10);
        check("first_hs_low", first_hs, 2 * (656 + 2));
        check("hs_period", hs_per, 1600);
        check("hs_low", hs_low, 192);
        check("vs_fall", vs_first, 2 * (490 * 800 + 2));
        check("vs_low", vs_low, 3200);
        check("fs_count", fs_cnt, 1);
        check("fs_at", fs_n, FRAME_CLK);
        check("max_raddr", max_ra, FB_DEPTH - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
